// File: rtl/conf_sequencer.sv
// conf_sequencer: buffers one target's configuration words, bursts them
// on conf_bus/sel/output_selector, then waits for that target's conf_ack.
//
// Ports:
//   conf_clk, reset (sync, active-low)
//   in_data/in_valid/in_ready : header and data word stream from the loader
//   conf_ack_vec              : per-target ack, indexed by select ID
//   conf_bus/sel/output_selector : burst to the selected target (sel 0 = idle)
//   busy, conf_done, err, err_code : status (err/err_code hold the first error)
// Optional feature: define CONF_SEQ_TIMEOUT_EN to give up on a missing ack
// after ACK_TIMEOUT cycles in WAIT_ACK (error code 3).

module conf_sequencer #(
  parameter int DIMENSION                = 3,
  parameter int SELECT_WIDTH             = 3,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int ACK_TIMEOUT              = 64
) (
  input  logic                                conf_clk,
  input  logic                                reset,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [(2**SELECT_WIDTH)-1:0]        conf_ack_vec,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] conf_bus,
  output logic [SELECT_WIDTH-1:0]             sel,
  output logic [DIMENSION-1:0]                output_selector,
  output logic                                busy,
  output logic                                conf_done,
  output logic                                err,
  output logic [1:0]                          err_code
);

  localparam int W  = ITERATION_VARIABLE_WIDTH;
  localparam int SW = SELECT_WIDTH;
  localparam int IW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [SW-1:0]    r_tgt;
  logic [SW-1:0]    w_tgt_nx;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nx;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nx;
  logic             r_drop;
  logic             w_drop_nx;
  logic [W-1:0]     r_buf [DIMENSION];

  logic             r_in_ready;
  logic [W-1:0]     r_bus;
  logic [W-1:0]     w_bus_nx;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    w_sel_nx;
  logic [DIMENSION-1:0] r_osel;
  logic [DIMENSION-1:0] w_osel_nx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_err_nx;
  logic [1:0]       r_code;
  logic [1:0]       w_code_nx;

  logic [SW-1:0]    w_htgt;
  logic [3:0]       w_hcnt;
  logic             w_hbad;
  logic             w_acc;
  logic             w_last;
  logic             w_ack;
  logic             w_tmo;
  logic [IW-1:0]    w_idx_inc;
  logic [DIMENSION-1:0] w_mask;
  logic             w_set_err;
  logic [1:0]       w_err_val;

  assign w_acc     = in_valid & r_in_ready;
  assign w_htgt    = in_data[SW-1:0];
  assign w_hcnt    = in_data[SW+3:SW];
  assign w_hbad    = (w_hcnt == 4'd0) ||
                     (32'(w_hcnt) > 32'(DIMENSION));
  // r_idx is the word slot in LOAD and the beat number in BURST
  assign w_last    = (32'(r_idx) == 32'(r_cnt) - 32'd1);
  assign w_idx_inc = r_idx + 1'b1;
  assign w_ack     = conf_ack_vec[r_tgt];

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < DIMENSION; j++) begin
      w_mask[j] = (32'(j) < 32'(r_cnt));
    end
  end

`ifdef CONF_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] r_tmo;

  always_ff @(posedge conf_clk) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state == S_WAIT) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_tmo = (r_state == S_WAIT) &&
                 (32'(r_tmo) == 32'(ACK_TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_tgt_nx   = r_tgt;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_drop_nx  = r_drop;
    w_bus_nx   = '0;
    w_sel_nx   = '0;
    w_osel_nx  = r_osel;
    w_set_err  = 1'b0;
    w_err_val  = 2'd0;

    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_htgt == '0) begin
            w_state_nx = S_DONE;
          end else if (w_hbad) begin
            w_set_err = 1'b1;
            w_err_val = 2'd1;
          end else begin
            // an already-acked target still gets its words drained
            w_tgt_nx   = w_htgt;
            w_cnt_nx   = w_hcnt;
            w_idx_nx   = '0;
            w_drop_nx  = conf_ack_vec[w_htgt];
            w_set_err  = conf_ack_vec[w_htgt];
            w_err_val  = 2'd2;
            w_state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          w_idx_nx = w_idx_inc;
          if (w_last) begin
            w_idx_nx = '0;
            if (r_drop) begin
              w_state_nx = S_IDLE;
            end else begin
              // beat 0 goes out on the very next cycle; with a
              // single-word set it is the word arriving now
              w_state_nx = S_BURST;
              w_sel_nx   = r_tgt;
              w_osel_nx  = w_mask;
              w_bus_nx   = (r_cnt == 4'd1) ? in_data : r_buf[0];
            end
          end
        end
      end
      S_BURST: begin
        if (w_last) begin
          w_idx_nx   = '0;
          w_state_nx = S_WAIT;
        end else begin
          w_idx_nx = w_idx_inc;
          w_sel_nx = r_tgt;
          w_bus_nx = r_buf[w_idx_inc];
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          w_osel_nx  = '0;
          w_state_nx = S_IDLE;
        end else if (w_tmo) begin
          w_osel_nx  = '0;
          w_set_err  = 1'b1;
          w_err_val  = 2'd3;
          w_state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nx = S_DONE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_err_nx  = r_err;
    w_code_nx = r_code;
    if (w_set_err && !r_err) begin
      w_err_nx  = 1'b1;
      w_code_nx = w_err_val;
    end
  end

  always_ff @(posedge conf_clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_drop     <= 1'b0;
      r_in_ready <= 1'b0;
      r_bus      <= '0;
      r_sel      <= '0;
      r_osel     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= 2'd0;
    end else begin
      r_state    <= w_state_nx;
      r_tgt      <= w_tgt_nx;
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_drop     <= w_drop_nx;
      r_in_ready <= (w_state_nx == S_IDLE) ||
                    (w_state_nx == S_LOAD);
      r_bus      <= w_bus_nx;
      r_sel      <= w_sel_nx;
      r_osel     <= w_osel_nx;
      r_busy     <= (w_state_nx == S_LOAD)  ||
                    (w_state_nx == S_BURST) ||
                    (w_state_nx == S_WAIT);
      r_done     <= (w_state_nx == S_DONE);
      r_err      <= w_err_nx;
      r_code     <= w_code_nx;
    end
  end

  always_ff @(posedge conf_clk) begin
    if (!reset) begin
      for (int k = 0; k < DIMENSION; k++) begin
        r_buf[k] <= '0;
      end
    end else if ((r_state == S_LOAD) && w_acc) begin
      r_buf[r_idx] <= in_data;
    end
  end

  assign in_ready        = r_in_ready;
  assign conf_bus        = r_bus;
  assign sel             = r_sel;
  assign output_selector = r_osel;
  assign busy            = r_busy;
  assign conf_done       = r_done;
  assign err             = r_err;
  assign err_code        = r_code;

endmodule

// File: tb/tb_conf_sequencer.sv
// tb_conf_sequencer: randomized self-checking bench for conf_sequencer
// with a stub receiver that acks when it latches the last burst word.

module tb_conf_sequencer;

  localparam int DIM = 3;
  localparam int SW  = 3;
  localparam int W   = 16;
`ifdef CONF_SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  typedef struct {
    logic [SW-1:0]  sel;
    logic [W-1:0]   bus;
    logic [DIM-1:0] osel;
    int             cyc;
  } obs_t;

  typedef struct {
    logic [SW-1:0]  sel;
    logic [W-1:0]   bus;
    logic [DIM-1:0] osel;
  } exp_t;

  typedef exp_t exp_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     ack_vec;
  logic [W-1:0]   conf_bus;
  logic [SW-1:0]  sel;
  logic [DIM-1:0] output_selector;
  logic           busy;
  logic           conf_done;
  logic           err;
  logic [1:0]     err_code;

  logic [7:0] stub_ack  = '0;
  logic [7:0] force_ack = '0;
  bit         stub_en   = 1'b1;
  int         rx_cnt    = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sel_cyc = 0;
  int last_busy_cyc = 0;
  obs_t obs_q[$];

  assign ack_vec = stub_ack | force_ack;

  conf_sequencer #(
    .DIMENSION(DIM),
    .SELECT_WIDTH(SW),
    .ITERATION_VARIABLE_WIDTH(W),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .conf_clk(clk),
    .reset(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .conf_ack_vec(ack_vec),
    .conf_bus(conf_bus),
    .sel(sel),
    .output_selector(output_selector),
    .busy(busy),
    .conf_done(conf_done),
    .err(err),
    .err_code(err_code)
  );

  // receiver stub: one word per sel cycle, ack pulse at the last latch
  always @(posedge clk) begin
    stub_ack <= '0;
    if (stub_en && sel != '0) begin
      if (rx_cnt + 1 == $countones(output_selector)) begin
        stub_ack[sel] <= 1'b1;
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end else begin
      rx_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (sel != '0) begin
      obs_q.push_back('{sel, conf_bus, output_selector, cyc});
      last_sel_cyc = cyc;
    end
    if (busy) last_busy_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] hdr(input logic [2:0] t,
                                       input logic [3:0] c);
    logic [W-1:0] h;
    h      = W'($urandom);
    h[2:0] = t;
    h[6:3] = c;
    return h;
  endfunction

  function automatic exp_q_t model_burst(input logic [2:0] t,
                                         input int c,
                                         input logic [W-1:0] w [DIM]);
    exp_q_t q;
    for (int i = 0; i < c; i++) begin
      q.push_back('{t, w[i], DIM'((1 << c) - 1)});
    end
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, output bit ok);
    int n = 0;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!ok && n < 40) begin
      if (in_ready === 1'b1) ok = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] t, input logic [3:0] c,
                      input logic [W-1:0] w [DIM],
                      input int stall_at, input int stall_len,
                      output bit ok);
    bit a;
    send(hdr(t, c), a);
    ok = a;
    for (int i = 0; i < int'(c); i++) begin
      if (i == stall_at) repeat (stall_len) tick();
      send(w[i], a);
      ok &= a;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (busy === 1'b0) ok = 1'b1;
      else tick();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, busy, conf_done, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b busy=%b done=%b err=%b want 0",
               in_ready, busy, conf_done, err);
    end
    checks++;
    if (sel !== '0 || conf_bus !== '0 || output_selector !== '0 ||
        err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_bus got sel=%0d bus=%h osel=%b code=%0d want 0",
               sel, conf_bus, output_selector, err_code);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_normal();
    logic [W-1:0] w [DIM];
    exp_q_t exp;
    bit ok;
    bit ok2;
    w = '{16'h0005, 16'h0003, 16'h0007};
    exp = model_burst(3'd6, 3, w);
    obs_q.delete();
    load(3'd6, 4'd3, w, -1, 0, ok);
    wait_idle(ok2);
    checks++;
    if (!ok || !ok2) begin
      errors++;
      $display("FAIL normal_handshake got acc=%b idle=%b want 1 1", ok, ok2);
    end
    checks++;
    if (obs_q.size() != exp.size()) begin
      errors++;
      $display("FAIL normal_len got %0d want %0d", obs_q.size(), exp.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp.size(); i++) begin
      checks++;
      if (obs_q[i].sel !== exp[i].sel || obs_q[i].bus !== exp[i].bus ||
          obs_q[i].osel !== exp[i].osel ||
          obs_q[i].cyc != obs_q[0].cyc + i) begin
        errors++;
        $display("FAIL normal_beat%0d got sel=%0d bus=%h osel=%b want sel=%0d bus=%h osel=%b",
                 i, obs_q[i].sel, obs_q[i].bus, obs_q[i].osel,
                 exp[i].sel, exp[i].bus, exp[i].osel);
      end
    end
    checks++;
    if (last_busy_cyc - last_sel_cyc != 1) begin
      errors++;
      $display("FAIL normal_wait got %0d want 1", last_busy_cyc - last_sel_cyc);
    end
    checks++;
    if (output_selector !== '0 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL normal_after got osel=%b rdy=%b err=%b want 000 1 0",
               output_selector, in_ready, err);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w [DIM];
    exp_q_t exp;
    bit ok;
    bit ok2;
    w = '{16'h0005, 16'h0003, 16'h0007};
    exp = model_burst(3'd6, 3, w);
    obs_q.delete();
    load(3'd6, 4'd3, w, 1, 4, ok);
    wait_idle(ok2);
    checks++;
    if (!ok || !ok2 || obs_q.size() != exp.size()) begin
      errors++;
      $display("FAIL stall_len got acc=%b idle=%b beats=%0d want 1 1 %0d",
               ok, ok2, obs_q.size(), exp.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp.size(); i++) begin
      checks++;
      if (obs_q[i].sel !== exp[i].sel || obs_q[i].bus !== exp[i].bus ||
          obs_q[i].osel !== exp[i].osel ||
          obs_q[i].cyc != obs_q[0].cyc + i) begin
        errors++;
        $display("FAIL stall_beat%0d got sel=%0d bus=%h osel=%b want sel=%0d bus=%h osel=%b",
                 i, obs_q[i].sel, obs_q[i].bus, obs_q[i].osel,
                 exp[i].sel, exp[i].bus, exp[i].osel);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w [DIM];
    exp_q_t exp;
    logic [2:0] t;
    int c;
    bit ok;
    bit ok2;
    for (int it = 0; it < 16; it++) begin
      t = 3'($urandom_range(1, 7));
      c = $urandom_range(1, DIM);
      for (int i = 0; i < DIM; i++) w[i] = W'($urandom);
      exp = model_burst(t, c, w);
      obs_q.delete();
      load(t, 4'(c), w, $urandom_range(0, c), $urandom_range(0, 3), ok);
      wait_idle(ok2);
      checks++;
      if (!ok || !ok2 || obs_q.size() != exp.size() ||
          last_busy_cyc - last_sel_cyc != 1) begin
        errors++;
        $display("FAIL rand%0d_len got acc=%b idle=%b beats=%0d wait=%0d want 1 1 %0d 1",
                 it, ok, ok2, obs_q.size(), last_busy_cyc - last_sel_cyc,
                 exp.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp.size(); i++) begin
        checks++;
        if (obs_q[i].sel !== exp[i].sel || obs_q[i].bus !== exp[i].bus ||
            obs_q[i].osel !== exp[i].osel ||
            obs_q[i].cyc != obs_q[0].cyc + i) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got sel=%0d bus=%h osel=%b want sel=%0d bus=%h osel=%b",
                   it, i, obs_q[i].sel, obs_q[i].bus, obs_q[i].osel,
                   exp[i].sel, exp[i].bus, exp[i].osel);
        end
      end
    end
  endtask

  task automatic test_bad_count();
    logic [W-1:0] w [DIM];
    exp_q_t exp;
    bit ok;
    bit ok2;
    do_reset();
    obs_q.delete();
    send(hdr(3'd5, 4'd0), ok);
    checks++;
    if (!ok || err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL badcnt0 got acc=%b err=%b code=%0d busy=%b want 1 1 1 0",
               ok, err, err_code, busy);
    end
    send(hdr(3'd5, 4'd4), ok);
    tick();
    checks++;
    if (!ok || err_code !== 2'd1 || busy !== 1'b0 || in_ready !== 1'b1 ||
        obs_q.size() != 0) begin
      errors++;
      $display("FAIL badcnt4 got acc=%b code=%0d busy=%b rdy=%b beats=%0d want 1 1 0 1 0",
               ok, err_code, busy, in_ready, obs_q.size());
    end
    for (int i = 0; i < DIM; i++) w[i] = W'($urandom);
    exp = model_burst(3'd5, 2, w);
    load(3'd5, 4'd2, w, -1, 0, ok);
    wait_idle(ok2);
    checks++;
    if (!ok || !ok2 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL badcnt_next_len got acc=%b idle=%b beats=%0d want 1 1 2",
               ok, ok2, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp.size(); i++) begin
      checks++;
      if (obs_q[i].sel !== exp[i].sel || obs_q[i].bus !== exp[i].bus ||
          obs_q[i].osel !== exp[i].osel) begin
        errors++;
        $display("FAIL badcnt_next_beat%0d got sel=%0d bus=%h osel=%b want sel=%0d bus=%h osel=%b",
                 i, obs_q[i].sel, obs_q[i].bus, obs_q[i].osel,
                 exp[i].sel, exp[i].bus, exp[i].osel);
      end
    end
  endtask

  task automatic test_already_acked();
    logic [W-1:0] w [DIM];
    exp_q_t exp;
    bit ok;
    bit ok2;
    bit ok3;
    do_reset();
    obs_q.delete();
    force_ack[6] = 1'b1;
    tick();
    send(hdr(3'd6, 4'd2), ok);
    force_ack = '0;
    send(16'h1111, ok2);
    send(16'h2222, ok3);
    repeat (3) tick();
    checks++;
    if (!(ok && ok2 && ok3) || obs_q.size() != 0) begin
      errors++;
      $display("FAIL acked_drain got acc=%b%b%b beats=%0d want 111 0",
               ok, ok2, ok3, obs_q.size());
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL acked_err got err=%b code=%0d busy=%b rdy=%b want 1 2 0 1",
               err, err_code, busy, in_ready);
    end
    w = '{16'hbeef, 16'h0, 16'h0};
    exp = model_burst(3'd2, 1, w);
    load(3'd2, 4'd1, w, -1, 0, ok);
    wait_idle(ok2);
    checks++;
    if (!ok || !ok2 || obs_q.size() != 1 || obs_q[0].sel !== exp[0].sel ||
        obs_q[0].bus !== exp[0].bus || obs_q[0].osel !== exp[0].osel) begin
      errors++;
      $display("FAIL acked_next got acc=%b idle=%b beats=%0d want 1 1 1 (sel=2 bus=beef osel=001)",
               ok, ok2, obs_q.size());
    end
  endtask

  task automatic test_ack_wait();
    logic [W-1:0] w [DIM];
    bit ok;
    bit ok2;
    w = '{16'haaaa, 16'h5555, 16'h0};
    do_reset();
    obs_q.delete();
    stub_en = 1'b0;
    load(3'd3, 4'd2, w, -1, 0, ok);
`ifdef CONF_SEQ_TIMEOUT_EN
    wait_idle(ok2);
    checks++;
    if (!ok || !ok2 || last_busy_cyc - last_sel_cyc != TMO) begin
      errors++;
      $display("FAIL timeout_len got acc=%b idle=%b wait=%0d want 1 1 %0d",
               ok, ok2, last_busy_cyc - last_sel_cyc, TMO);
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || output_selector !== '0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got err=%b code=%0d osel=%b rdy=%b want 1 3 000 1",
               err, err_code, output_selector, in_ready);
    end
`else
    ok2 = 1'b1;
    repeat (100) tick();
    checks++;
    if (!ok || busy !== 1'b1 || output_selector !== 3'b011 ||
        sel !== '0 || conf_bus !== '0) begin
      errors++;
      $display("FAIL ackwait_hold got acc=%b busy=%b osel=%b sel=%0d bus=%h want 1 1 011 0 0",
               ok, busy, output_selector, sel, conf_bus);
    end
    force_ack[3] = 1'b1;
    tick();
    force_ack = '0;
    tick();
    checks++;
    if (!ok2 || busy !== 1'b0 || output_selector !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL ackwait_release got busy=%b osel=%b err=%b want 0 000 0",
               busy, output_selector, err);
    end
`endif
    stub_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [W-1:0] w [DIM];
    bit ok;
    w = '{16'h1234, 16'h5678, 16'h9abc};
    load(3'd4, 4'd3, w, -1, 0, ok);
    checks++;
    if (!ok || sel !== 3'd4) begin
      errors++;
      $display("FAIL midburst_start got acc=%b sel=%0d want 1 4", ok, sel);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (sel !== '0 || busy !== 1'b0 || output_selector !== '0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset got sel=%0d busy=%b osel=%b rdy=%b want 0 0 000 0",
               sel, busy, output_selector, in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || sel !== '0) begin
      errors++;
      $display("FAIL midburst_release got rdy=%b sel=%0d want 1 0",
               in_ready, sel);
    end
  endtask

  task automatic test_done_reset();
    bit ok;
    send(hdr(3'd0, 4'($urandom)), ok);
    checks++;
    if (!ok || conf_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0) begin
      errors++;
      $display("FAIL done_enter got acc=%b done=%b rdy=%b busy=%b err=%b want 1 1 0 0 0",
               ok, conf_done, in_ready, busy, err);
    end
    in_data  = hdr(3'd5, 4'd2);
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    checks++;
    if (conf_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got done=%b rdy=%b busy=%b want 1 0 0",
               conf_done, in_ready, busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, busy, conf_done, err} !== 4'b0 || sel !== '0 ||
        conf_bus !== '0 || output_selector !== '0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL done_reset got rdy=%b busy=%b done=%b err=%b sel=%0d bus=%h osel=%b code=%0d want all 0",
               in_ready, busy, conf_done, err, sel, conf_bus,
               output_selector, err_code);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || conf_done !== 1'b0) begin
      errors++;
      $display("FAIL done_release got rdy=%b done=%b want 1 0",
               in_ready, conf_done);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    test_reset();
    test_normal();
    test_stall();
    test_random();
    test_bad_count();
    test_already_acked();
    test_ack_wait();
    test_reset_mid_burst();
    test_done_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conf_sequencer.md
# conf_sequencer

Configuration transmitter for the global controller. It accepts a stream of configuration words from the host-side loader, buffers each target's register set, and bursts it onto the shared `conf_bus`/`sel`/`output_selector` lines. It then waits for the selected sub-block's `conf_ack`. It is the driving end of the per-block load protocol used by the controller sub-blocks, for example the rectangular reinitializer at select ID 6.

## Interface
- `DIMENSION`, 3, maximum number of words in one target's register set.
- `SELECT_WIDTH`, 3, width of the target select ID.
- `ITERATION_VARIABLE_WIDTH`, 16, configuration word width.
- `ACK_TIMEOUT`, 64, cycles to wait for ack (only with `CONF_SEQ_TIMEOUT_EN`).
- `conf_clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_data` in `ITERATION_VARIABLE_WIDTH`: incoming header/data word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: word accepted on a cycle where `in_valid & in_ready`.
- `conf_ack_vec` in `2**SELECT_WIDTH`: `conf_ack` of each sub-block, indexed by select ID.
- `conf_bus` out `ITERATION_VARIABLE_WIDTH`: configuration word to the targets.
- `sel` out `SELECT_WIDTH`: target select. 0 means idle and no target.
- `output_selector` out `DIMENSION`: thermometer mask of the burst length.
- `busy` out 1: high in any state other than IDLE and DONE.
- `conf_done` out 1: end-of-program marker was consumed.
- `err` out 1: sticky error flag.
- `err_code` out 2: code of the first error. 1 = bad count, 2 = target already acked, 3 = ack timeout.

## Operation
- Header word: `tgt = in_data[SELECT_WIDTH-1:0]`, `cnt = in_data[SELECT_WIDTH+3:SELECT_WIDTH]`. The remaining bits are ignored.
- FSM states: IDLE, LOAD, BURST, WAIT_ACK, DONE.
- **IDLE:** `in_ready`=1. On header acceptance:
  - `tgt`=0: go to DONE.
  - `cnt`=0 or `cnt`>`DIMENSION`: set error code 1 and stay in IDLE. The header is dropped.
  - `conf_ack_vec[tgt]`=1: set error code 2 and go to LOAD anyway, so the data words are drained. The burst is then suppressed and the FSM returns to IDLE.
  - Otherwise: latch `tgt` and `cnt`, clear the word index, go to LOAD.
- **LOAD:** `in_ready`=1. Each accepted word is written to `buf[idx]` and `idx` increments. The FSM leaves LOAD on the cycle the `cnt`-th word is accepted.
- **BURST:** exactly `cnt` consecutive cycles. `sel=tgt`, `conf_bus=buf[i]` for i=0..cnt-1, `output_selector=(1<<cnt)-1`. There are no gaps: the receiver latches one word per cycle. Then go to WAIT_ACK.
- **WAIT_ACK:** `sel`=0 and `conf_bus`=0. `output_selector` holds its value. When `conf_ack_vec[tgt]`=1, clear `output_selector` and go to IDLE.
- **DONE:** `in_ready`=0 and `conf_done`=1, until reset.
- Errors: only the first error code is recorded. `err` and `err_code` clear only on reset.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after reset is released. `conf_bus`=0, `sel`=0, `output_selector`=0, `busy`=0, `conf_done`=0, `err`=0, `err_code`=0. FSM goes to IDLE; buffer and index are cleared.
- All outputs are registered.
- The first BURST cycle is the cycle after the last LOAD acceptance.
- Header to first `sel` cycle: at least `cnt`+1 cycles; input stalls extend this.
- Ack latency: the receiver raises ack at the edge latching the last word. The sequencer therefore sees ack on the first WAIT_ACK cycle, and WAIT_ACK lasts 1 cycle nominally.
- `in_valid` low in LOAD stalls the load only. BURST is never stalled once started.
- Reset asserted mid-BURST: `sel`=0 on the next edge. The partial load is abandoned; the target is recovered by its own reset.

## Configuration
- `CONF_SEQ_TIMEOUT_EN` defined: a counter runs in WAIT_ACK. If `conf_ack_vec[tgt]` is still 0 after `ACK_TIMEOUT` cycles, set error code 3, clear `output_selector` and go to IDLE.
- `CONF_SEQ_TIMEOUT_EN` undefined: no counter; WAIT_ACK waits indefinitely. `ACK_TIMEOUT` is unused.

## Test plan
- **Normal load.** Header tgt=6, cnt=3, then words 0x0005, 0x0003, 0x0007. The stub receiver acks at its third latch.
  - `sel`=6 for exactly 3 cycles with `conf_bus` = 5, 3, 7 in order.
  - `output_selector`=3'b111; back to IDLE one cycle after the burst.
- **Input stall.** Same load with `in_valid` low for 4 cycles between words 1 and 2: burst is still 3 contiguous cycles with identical values.
- **Bad count.** Header cnt=0, then cnt=4 with DIMENSION=3.
  - `err`=1, `err_code`=1 after the first.
  - No `sel` activity; the next valid header is processed normally.
- **Already acked.** `conf_ack_vec[6]`=1, then header tgt=6, cnt=2 plus 2 words.
  - Both words are drained; `sel` stays 0.
  - `err_code`=2.
- **Timeout** (`CONF_SEQ_TIMEOUT_EN`, `ACK_TIMEOUT`=8). Receiver never acks: after 8 WAIT_ACK cycles `err_code`=3, FSM in IDLE, `output_selector`=0.
- **End and reset.** Header tgt=0: `conf_done`=1 and `in_ready`=0 thereafter. Then `reset`=0 for 1 cycle: all outputs 0; `in_ready`=1 on the following cycle.
